// File: rtl/data_mem_responder.sv
// Purpose: data-memory responder for the MEM stage; word storage with fixed wait states and access-error flagging.
// Latency: request accepted in IDLE, WAIT_CYCLES wait cycles, then a one-cycle DONE with ready (result in cycle N+WAIT_CYCLES+1).
// Backpressure: memStall holds the pipeline from the request cycle through the last wait cycle; inputs are ignored outside IDLE.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        memStall,
    output logic        ready,
    output logic        accessErr
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic                  lat_write;
    logic                  lat_err;
    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic                  req_err;
    logic                  finish_acc;
    logic                  commit_wr;

    // Upper address bits only alias the storage; they are deliberately dropped.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^address[31:DEPTH_LOG2+2];

    assign req        = memRead | memWrite;
    // Simultaneous read+write or a non word-aligned address is rejected.
    assign req_err    = (memRead & memWrite) | (address[1:0] != 2'b00);
    assign finish_acc = (state == WAIT) && (cnt == 4'd0);
    assign commit_wr  = finish_acc && lat_write && !lat_err;

    // Stall is combinational so the requesting cycle is already held; forced low in reset.
    always_comb begin
        memStall = 1'b0;
        if (rst) begin
            memStall = ((state == IDLE) && req) || (state == WAIT);
        end
    end

    // Control FSM: latch the request in IDLE, count wait states, complete in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            readData  <= 32'd0;
            ready     <= 1'b0;
            accessErr <= 1'b0;
        end else begin
            ready     <= 1'b0;
            accessErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= WAIT;
                        cnt       <= CNT_LOAD;
                        lat_idx   <= address[DEPTH_LOG2+1:2];
                        lat_wdata <= writeData;
                        lat_write <= memWrite;
                        lat_err   <= req_err;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        ready     <= 1'b1;
                        accessErr <= lat_err;
                        // readData only moves on a good read; writes and rejects keep it.
                        if (!lat_err && !lat_write) begin
                            readData <= mem[lat_idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // The pipeline advances at this edge, so always fall back to IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage: cleared by reset, written only at the WAIT-to-DONE edge of a good write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (commit_wr) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule
